// File: rtl/alu_trace_buffer_pkg.sv
// Shared constants for the ALU trace buffer: default depth and read-index width.
package alu_trace_buffer_pkg;

  localparam int unsigned INSA_TRACE_DEPTH = 256;
  localparam int unsigned TRACE_DATA_W     = 32;
  localparam int unsigned RD_INDEX_W       = 20;

endpackage

// File: rtl/alu_trace_buffer_if.sv
// Producer/ALU-side bundle for the trace buffer: capture strobe, flush, logical read port and status.
interface alu_trace_buffer_if
  import alu_trace_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = INSA_TRACE_DEPTH,
  parameter int unsigned DATA_W = TRACE_DATA_W
) ();

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                  clear_i;
  logic                  wr_valid_i;
  logic [DATA_W-1:0]     wr_data_i;
  logic [RD_INDEX_W-1:0] rd_index_i;
  logic [DATA_W-1:0]     rd_data_o;
  logic                  rd_hit_o;
  logic [CW-1:0]         count_o;
  logic                  full_o;
  logic                  overflow_o;

  modport master (
    output clear_i, wr_valid_i, wr_data_i, rd_index_i,
    input  rd_data_o, rd_hit_o, count_o, full_o, overflow_o
  );

  modport slave (
    input  clear_i, wr_valid_i, wr_data_i, rd_index_i,
    output rd_data_o, rd_hit_o, count_o, full_o, overflow_o
  );

endinterface

// File: rtl/alu_trace_buffer.sv
// Circular trace buffer that overwrites the oldest entry when full; logical index 0 is the oldest entry.
module alu_trace_buffer
  import alu_trace_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = INSA_TRACE_DEPTH,
  parameter int unsigned DATA_W = TRACE_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  alu_trace_buffer_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     optr;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              full;
  logic              wr_en;
  logic              hit;
  logic [AW-1:0]     rd_addr;

  assign full  = (count == CW'(DEPTH));
  assign wr_en = bus.wr_valid_i && !bus.clear_i;

  // Pointer/count state; clear wins over a coincident write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr     <= '0;
      optr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (bus.clear_i) begin
      wptr     <= '0;
      optr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (bus.wr_valid_i) begin
      wptr <= wptr + AW'(1);
      if (full) begin
        optr     <= optr + AW'(1);
        overflow <= 1'b1;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

  // Storage is never reset; a write sampled while reset is held is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_ni && wr_en) begin
      mem[wptr] <= bus.wr_data_i;
    end
  end

  // Full 20-bit index compare so aliased upper bits never produce a hit.
  assign hit     = (bus.rd_index_i < RD_INDEX_W'(count));
  assign rd_addr = optr + bus.rd_index_i[AW-1:0];

  assign bus.rd_hit_o   = hit;
  assign bus.rd_data_o  = hit ? mem[rd_addr] : '0;
  assign bus.count_o    = count;
  assign bus.full_o     = full;
  assign bus.overflow_o = overflow;

endmodule

// File: tb/tb_alu_trace_buffer.sv
// Self-checking bench for alu_trace_buffer (DEPTH=4) using a queue model of the valid entries.
module tb_alu_trace_buffer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 32;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] model [$];
  logic              ovf_m;

  alu_trace_buffer_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

  alu_trace_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [DATA_W-1:0] d);
    bus.wr_valid_i = 1'b1;
    bus.wr_data_i  = d;
    model.push_back(d);
    if (model.size() > DEPTH) begin
      void'(model.pop_front());
      ovf_m = 1'b1;
    end
    step();
    bus.wr_valid_i = 1'b0;
  endtask

  task automatic rd(input logic [19:0] idx);
    bus.rd_index_i = idx;
    #1;
  endtask

  task automatic do_clear();
    bus.clear_i = 1'b1;
    model.delete();
    ovf_m = 1'b0;
    step();
    bus.clear_i = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, 32'(bus.count_o), 32'(model.size()));
    check({tag, "_full"}, 32'(bus.full_o), 32'(model.size() == DEPTH));
    check({tag, "_ovf"}, 32'(bus.overflow_o), 32'(ovf_m));
  endtask

  // Pops the model oldest-first and compares against logical indices 0,1,2,...
  task automatic drain_check(input string tag);
    logic [DATA_W-1:0] e;
    for (int i = 0; model.size() > 0; i++) begin
      rd(20'(i));
      e = model.pop_front();
      check($sformatf("%s_hit%0d", tag, i), 32'(bus.rd_hit_o), 32'd1);
      check($sformatf("%s_data%0d", tag, i), bus.rd_data_o, e);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    ovf_m          = 1'b0;
    bus.clear_i    = 1'b0;
    bus.wr_valid_i = 1'b0;
    bus.wr_data_i  = '0;
    bus.rd_index_i = '0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Reset state
    rd(20'd0);
    check("rst_hit", 32'(bus.rd_hit_o), 32'd0);
    check("rst_data", bus.rd_data_o, 32'd0);
    check_status("rst");

    // Three consecutive writes, hit/miss and aliased-index reads
    wr(32'hA0);
    wr(32'hA1);
    wr(32'hA2);
    rd(20'd1);
    check("idx1_hit", 32'(bus.rd_hit_o), 32'd1);
    check("idx1_data", bus.rd_data_o, 32'hA1);
    rd(20'd3);
    check("idx3_hit", 32'(bus.rd_hit_o), 32'd0);
    check("idx3_data", bus.rd_data_o, 32'd0);
    rd(20'h10001);
    check("alias_hit", 32'(bus.rd_hit_o), 32'd0);
    check("alias_data", bus.rd_data_o, 32'd0);
    check_status("three");
    drain_check("three");
    do_clear();

    // Overflow wrap: 1..6 into depth 4
    for (int v = 1; v <= 6; v++) wr(32'(v));
    check_status("ovf");
    drain_check("ovf");

    // Clear and write together on a full buffer: write dropped
    bus.clear_i    = 1'b1;
    bus.wr_valid_i = 1'b1;
    bus.wr_data_i  = 32'hFF;
    model.delete();
    ovf_m = 1'b0;
    step();
    bus.clear_i    = 1'b0;
    bus.wr_valid_i = 1'b0;
    rd(20'd0);
    check("clrw_hit", 32'(bus.rd_hit_o), 32'd0);
    check_status("clrw");
    wr(32'h77);
    check_status("clrw_next");
    drain_check("clrw_next");
    do_clear();

    // No write bypass: miss in cycle N, hit in N+1
    rd(20'd0);
    bus.wr_valid_i = 1'b1;
    bus.wr_data_i  = 32'h55;
    #1;
    check("byp_hitN", 32'(bus.rd_hit_o), 32'd0);
    check("byp_dataN", bus.rd_data_o, 32'd0);
    model.push_back(32'h55);
    step();
    bus.wr_valid_i = 1'b0;
    #1;
    check("byp_hitN1", 32'(bus.rd_hit_o), 32'd1);
    check("byp_dataN1", bus.rd_data_o, 32'h55);
    do_clear();

    // Async reset mid-burst, coincident write discarded, first write after lands at index 0
    wr(32'hC0);
    wr(32'hC1);
    bus.wr_valid_i = 1'b1;
    bus.wr_data_i  = 32'hC2;
    rd(20'd0);
    #1;
    rst_n = 1'b0;
    model.delete();
    ovf_m = 1'b0;
    #1;
    check_status("arst");
    check("arst_hit", 32'(bus.rd_hit_o), 32'd0);
    check("arst_data", bus.rd_data_o, 32'd0);
    step();
    check("arst_hold_count", 32'(bus.count_o), 32'd0);
    bus.wr_valid_i = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    check_status("arst_rel");
    wr(32'h99);
    check_status("arst_wr");
    drain_check("arst_wr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_trace_buffer.md
ALU_TRACE_BUFFER -- requirements
Module: alu_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 32-bit entries; power of two, 2..4096.
REQ-002 SHALL have parameter DATA_W, default 32, entry width; matches the ALU read-data port.
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port clear_i  input  1  synchronous flush of all buffer state.
REQ-006 SHALL have port wr_valid_i  input  1  capture strobe from the producing stage.
REQ-007 SHALL have port wr_data_i  input  DATA_W  word to capture.
REQ-008 SHALL have port rd_index_i  input  20  logical read index, driven by the ALU from the instruction immediate.
REQ-009 SHALL have port rd_data_o  output  DATA_W  entry at rd_index_i; feeds the ALU read-out input.
REQ-010 SHALL have port rd_hit_o  output  1  rd_index_i addresses a valid entry; feeds the ALU data-in-buffer input.
REQ-011 SHALL have port count_o  output  clog2(DEPTH)+1  number of valid entries.
REQ-012 SHALL have port full_o  output  1  count_o == DEPTH.
REQ-013 SHALL have port overflow_o  output  1  sticky flag: at least one entry has been overwritten since the last clear or reset.

Function
REQ-014 SHALL act as a circular buffer: write pointer wptr and oldest pointer optr, both clog2(DEPTH) bits, wrapping modulo DEPTH.
REQ-015 SHALL, on wr_valid_i=1 with clear_i=0, store wr_data_i at wptr and increment wptr by 1 mod DEPTH.
REQ-016 SHALL, on a write while count_o<DEPTH, increment count_o by 1 and leave optr unchanged.
REQ-017 SHALL, on a write while count_o==DEPTH, overwrite the oldest entry, increment optr mod DEPTH, hold count_o and set overflow_o.
REQ-018 SHALL map logical index 0 to the oldest entry: physical address = (optr + rd_index_i[clog2(DEPTH)-1:0]) mod DEPTH.
REQ-019 SHALL drive rd_hit_o=1 only when the full 20-bit rd_index_i < count_o; upper index bits are never ignored.
REQ-020 SHALL drive rd_data_o combinationally, with zero-cycle latency, from the addressed entry when rd_hit_o=1, and drive all zeros otherwise.
REQ-021 SHALL NOT bypass writes: an entry written in cycle N becomes readable in cycle N+1.
REQ-022 SHALL, on clear_i=1, zero wptr, optr, count_o and overflow_o at the next edge, leaving storage contents untouched.
REQ-023 SHALL give clear_i priority over a simultaneous wr_valid_i; that write is dropped and count_o is 0 in the next cycle.
REQ-024 SHALL keep all outputs other than rd_data_o and rd_hit_o registered or derived only from registered state.

Reset
REQ-025 SHALL, on rst_ni=0, asynchronously set wptr, optr, count_o and overflow_o to 0, which forces full_o=0, rd_hit_o=0 and rd_data_o=0.
REQ-026 SHALL NOT reset the storage array; validity is defined by count_o alone.
REQ-027 SHALL discard any write coincident with reset assertion, and the first write after deassertion lands at physical 0.

Structure
REQ-028 SHALL take DEPTH from a shared constant INSA_TRACE_DEPTH in ariane_pkg, next to the DEBUG operator encodings.
REQ-029 SHALL infer storage inline as a single DEPTH x DATA_W register array; no sub-module is needed.
REQ-030 SHALL connect rd_index_i, rd_data_o and rd_hit_o point-to-point to the ALU with no intermediate registers.

Verification
REQ-031 SHALL cover: reset, then rd_index_i=0 -> rd_hit_o=0, rd_data_o=0, count_o=0, full_o=0.
REQ-032 SHALL cover: write 0xA0, 0xA1, 0xA2 on consecutive cycles; index 1 -> 0xA1, hit=1; index 3 -> hit=0, data=0; index 0x10001 -> hit=0.
REQ-033 SHALL cover, with DEPTH=4: write 1..6 -> count_o=4, full_o=1, overflow_o=1; indices 0..3 read 3,4,5,6.
REQ-034 SHALL cover: write 0x55 in cycle N while reading index 0 on an empty buffer -> hit=0 in cycle N, and data 0x55 with hit=1 in cycle N+1.
REQ-035 SHALL cover: clear_i and wr_valid_i (0xFF) in the same cycle on a full buffer -> next cycle count_o=0, overflow_o=0, hit=0; the next write reads back at index 0.
REQ-036 SHALL cover: rst_ni asserted mid-burst between clock edges -> count_o=0 immediately, before the next edge, and no stale entry is visible.
